// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding ROM request FSM feeding a small
// in-order instruction buffer whose head is presented to decode.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);
    localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_addr;
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic [31:0]   buf_inst [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic          req;
    logic          accept;
    logic          push;
    logic          pop;
    logic          has_data;
    logic [31:0]   cur_addr;

    always_comb begin
        has_data = (count != '0);
        case (state)
            S_IDLE:         req = (count < DEPTH_C);
            S_WAIT, S_DROP: req = 1'b1;
            default:        req = 1'b0;
        endcase
        // In WAIT/DROP the address is the one latched at issue, so a flush
        // that moves fetch_pc cannot disturb the request on the bus.
        cur_addr = (state == S_IDLE) ? fetch_pc : req_addr;
        accept   = req && rom_ack_i;
        push     = accept && (state != S_DROP) && !flush_i;
        pop      = has_data && id_ready_i && !flush_i;
    end

    always_comb begin
        rom_req_o  = req && !rst;
        rom_addr_o = rom_req_o ? cur_addr : '0;
        id_valid_o = has_data && !rst;
        pc_o       = id_valid_o ? buf_pc[rd_ptr]   : '0;
        inst_o     = id_valid_o ? buf_inst[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]   <= cur_addr;
            buf_inst[wr_ptr] <= rom_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            req_addr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && !rom_ack_i) begin
                        req_addr <= fetch_pc;
                        state    <= flush_i ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rom_ack_i)    state <= S_IDLE;
                    else if (flush_i) state <= S_DROP;
                end
                S_DROP: begin
                    if (rom_ack_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (flush_i) begin
                fetch_pc <= {flush_pc_i[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= cur_addr + 32'd4;
                    wr_ptr   <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PW + 1)'(1);
                    2'b01:   count <= count - (PW + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule
